mem_seq_ctrl: RTL and testbench

MEM_SEQ_CTRL -- requirements
Module: mem_seq_ctrl

---
 rtl/mem_seq_ctrl_pkg.sv | 17 +
 rtl/mem_seq_ram.sv | 33 +++
 rtl/mem_seq_top.sv | 57 +++++
 rtl/mem_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_mem_seq_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_seq_ctrl_pkg.sv
// Shared types and default geometry for the frame record/playback sequencer.
package mem_seq_ctrl_pkg;

    localparam int unsigned ROW_DEF       = 19;
    localparam int unsigned DEPTH_DEF     = 128;
    localparam int unsigned LOG_DEPTH_DEF = 7;
    localparam int unsigned REP_W         = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DISCARD,
        S_GAP,
        S_PLAY
    } state_t;

endpackage

// File: rtl/mem_seq_ram.sv
// Single-port-per-direction buffer whose addresses auto-advance on strobes
// and rewind to zero on any cycle with both strobes low.
module mem_seq_ram
    import mem_seq_ctrl_pkg::*;
#(
    parameter int unsigned ROW       = ROW_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned LOG_DEPTH = LOG_DEPTH_DEF
) (
    input  logic           clk,
    input  logic           we,
    input  logic           en,
    input  logic [ROW-1:0] data_in,
    output logic [ROW-1:0] data_out
);

    logic [ROW-1:0]       mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_addr;
    logic [LOG_DEPTH-1:0] rd_addr;

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= data_in;
        if (en) data_out <= mem[rd_addr];
        if (!we && !en) begin
            wr_addr <= '0;
            rd_addr <= '0;
        end else begin
            if (we) wr_addr <= wr_addr + LOG_DEPTH'(1);
            if (en) rd_addr <= rd_addr + LOG_DEPTH'(1);
        end
    end

endmodule

// File: rtl/mem_seq_top.sv
// Sequencer paired with its frame buffer.
module mem_seq_top
    import mem_seq_ctrl_pkg::*;
#(
    parameter int unsigned ROW       = ROW_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned LOG_DEPTH = LOG_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [ROW-1:0]   in_data,
    input  logic [REP_W-1:0] cfg_repeat,
    output logic             out_valid,
    output logic             out_last,
    output logic [ROW-1:0]   out_data,
    output logic             busy,
    output logic             err_gap,
    output logic             err_ovf
);

    logic           mem_we;
    logic           mem_en;
    logic [ROW-1:0] mem_din;
    logic [ROW-1:0] mem_dout;

    mem_seq_ctrl #(.ROW(ROW), .DEPTH(DEPTH), .LOG_DEPTH(LOG_DEPTH)) u_ctrl (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_data    (in_data),
        .cfg_repeat (cfg_repeat),
        .mem_we     (mem_we),
        .mem_en     (mem_en),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_data   (out_data),
        .busy       (busy),
        .err_gap    (err_gap),
        .err_ovf    (err_ovf)
    );

    mem_seq_ram #(.ROW(ROW), .DEPTH(DEPTH), .LOG_DEPTH(LOG_DEPTH)) u_mem (
        .clk      (clk),
        .we       (mem_we),
        .en       (mem_en),
        .data_in  (mem_din),
        .data_out (mem_dout)
    );

endmodule

// File: rtl/mem_seq_ctrl.sv
// Records one input frame into the buffer, then replays it cfg_repeat times
// with a single idle cycle between repeats.
module mem_seq_ctrl
    import mem_seq_ctrl_pkg::*;
#(
    parameter int unsigned ROW       = ROW_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned LOG_DEPTH = LOG_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [ROW-1:0]   in_data,
    input  logic [REP_W-1:0] cfg_repeat,
    output logic             mem_we,
    output logic             mem_en,
    output logic [ROW-1:0]   mem_din,
    input  logic [ROW-1:0]   mem_dout,
    output logic             out_valid,
    output logic             out_last,
    output logic [ROW-1:0]   out_data,
    output logic             busy,
    output logic             err_gap,
    output logic             err_ovf
);

    localparam int unsigned   CW      = LOG_DEPTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, len, rd_cnt;
    logic [REP_W-1:0] rep;

    logic          accept;
    logic [CW-1:0] cnt_nx;
    logic          play_done;
    logic          last_rep;
    logic          gap_c;
    logic          ovf_c;

    assign accept    = in_valid & in_ready;
    assign cnt_nx    = cnt + CW'(1);
    assign play_done = (state == S_PLAY) && (rd_cnt == len - CW'(1));
    assign last_rep  = (rep <= REP_W'(1));
    assign gap_c     = (state == S_LOAD) && !in_valid;
    assign ovf_c     = (state == S_LOAD) && in_valid && !in_last && (cnt_nx == DEPTH_C);

    always_ff @(posedge clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (accept) state_nx = in_last ? S_GAP : S_LOAD;
            S_LOAD: begin
                if (!in_valid)              state_nx = S_IDLE;
                else if (in_last)           state_nx = S_GAP;
                else if (cnt_nx == DEPTH_C) state_nx = S_DISCARD;
            end
            S_DISCARD: if (in_valid && in_last) state_nx = S_GAP;
            S_GAP:     state_nx = S_PLAY;
            S_PLAY:    if (play_done) state_nx = last_rep ? S_IDLE : S_GAP;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Strobes are forced low while reset is held so the buffer never sees a stray access.
    always_comb begin
        in_ready = 1'b0;
        mem_we   = 1'b0;
        mem_en   = 1'b0;
        mem_din  = in_data;
        busy     = (state != S_IDLE) || out_valid;
        out_data = out_valid ? mem_dout : '0;
        case (state)
            S_IDLE, S_LOAD: begin
                in_ready = 1'b1;
                mem_we   = rstn & in_valid;
            end
            S_DISCARD: in_ready = 1'b1;
            S_PLAY:    mem_en   = rstn;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt       <= '0;
            len       <= '0;
            rd_cnt    <= '0;
            rep       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            err_gap   <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            err_gap   <= gap_c;
            err_ovf   <= ovf_c;
            out_valid <= mem_en;
            out_last  <= mem_en && play_done && last_rep;
            case (state)
                S_IDLE: if (accept) begin
                    cnt <= CW'(1);
                    rep <= (cfg_repeat == '0) ? REP_W'(1) : cfg_repeat;
                    if (in_last) len <= CW'(1);
                end
                S_LOAD: if (in_valid) begin
                    cnt <= cnt_nx;
                    if (in_last)                len <= cnt_nx;
                    else if (cnt_nx == DEPTH_C) len <= DEPTH_C;
                end
                S_GAP:  rd_cnt <= '0;
                S_PLAY: begin
                    rd_cnt <= rd_cnt + CW'(1);
                    if (play_done && !last_rep) rep <= rep - REP_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Randomized bench for mem_seq_ctrl: frames are turned into an expected
// cycle-indexed playback map that a negedge monitor checks every cycle.
module tb_mem_seq_ctrl;
    import mem_seq_ctrl_pkg::*;

    localparam int unsigned ROW       = ROW_DEF;
    localparam int unsigned DEPTH     = DEPTH_DEF;
    localparam int unsigned LOG_DEPTH = LOG_DEPTH_DEF;

    typedef logic [ROW-1:0] word_t;

    logic             clk = 1'b0;
    logic             rstn;
    logic             in_valid, in_ready, in_last;
    word_t            in_data;
    logic [REP_W-1:0] cfg_repeat;
    logic             mem_we, mem_en;
    word_t            mem_din, mem_dout;
    logic             out_valid, out_last, busy, err_gap, err_ovf;
    word_t            out_data;

    logic             t_in_ready, t_out_valid, t_out_last, t_busy, t_err_gap, t_err_ovf;
    word_t            t_out_data;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    word_t exp_data [int];
    logic  exp_last [int];
    int    ovf_q [$];
    int    gap_q [$];
    bit    mon_ev;

    mem_seq_ctrl #(.ROW(ROW), .DEPTH(DEPTH), .LOG_DEPTH(LOG_DEPTH)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_data(in_data), .cfg_repeat(cfg_repeat),
        .mem_we(mem_we), .mem_en(mem_en), .mem_din(mem_din), .mem_dout(mem_dout),
        .out_valid(out_valid), .out_last(out_last), .out_data(out_data),
        .busy(busy), .err_gap(err_gap), .err_ovf(err_ovf)
    );

    mem_seq_ram #(.ROW(ROW), .DEPTH(DEPTH), .LOG_DEPTH(LOG_DEPTH)) u_mem (
        .clk(clk), .we(mem_we), .en(mem_en), .data_in(mem_din), .data_out(mem_dout)
    );

    mem_seq_top #(.ROW(ROW), .DEPTH(DEPTH), .LOG_DEPTH(LOG_DEPTH)) u_top (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(t_in_ready),
        .in_last(in_last), .in_data(in_data), .cfg_repeat(cfg_repeat),
        .out_valid(t_out_valid), .out_last(t_out_last), .out_data(t_out_data),
        .busy(t_busy), .err_gap(t_err_gap), .err_ovf(t_err_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle playback check against the expected map, plus wrapper equivalence.
    always @(negedge clk) begin
        mon_ev = exp_data.exists(cyc);
        n_checks++;
        if (mon_ev) begin
            if (out_valid !== 1'b1 || out_data !== exp_data[cyc] || out_last !== exp_last[cyc]) begin
                n_fail++;
                $display("FAIL playback cyc=%0d got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                         cyc, out_valid, out_data, out_last, exp_data[cyc], exp_last[cyc]);
            end
            exp_data.delete(cyc);
            exp_last.delete(cyc);
        end else if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_out cyc=%0d got v=%b d=%h l=%b expected v=0 d=0 l=0",
                     cyc, out_valid, out_data, out_last);
        end
        n_checks++;
        if ({t_in_ready, t_out_valid, t_out_last, t_out_data, t_busy, t_err_gap, t_err_ovf} !==
            {in_ready, out_valid, out_last, out_data, busy, err_gap, err_ovf}) begin
            n_fail++;
            $display("FAIL top_equiv cyc=%0d got %h expected %h", cyc,
                     {t_in_ready, t_out_valid, t_out_last, t_out_data, t_busy, t_err_gap, t_err_ovf},
                     {in_ready, out_valid, out_last, out_data, busy, err_gap, err_ovf});
        end
        if (err_ovf === 1'b1) ovf_q.push_back(cyc);
        if (err_gap === 1'b1) gap_q.push_back(cyc);
    end

    // Expected playback: every repeat starts len+1 cycles after the previous one, first at t_last+3.
    function automatic void model_frame(input word_t w[$], input logic [REP_W-1:0] rep, input int t_last);
        int r_n = (rep == 0) ? 1 : int'(rep);
        int len = (w.size() > int'(DEPTH)) ? int'(DEPTH) : w.size();
        for (int r = 0; r < r_n; r++)
            for (int i = 0; i < len; i++) begin
                exp_data[t_last + 3 + r * (len + 1) + i] = w[i];
                exp_last[t_last + 3 + r * (len + 1) + i] = (r == r_n - 1) && (i == len - 1);
            end
    endfunction

    task automatic drive_frame(input word_t w[$], input logic [REP_W-1:0] rep, input bit with_last,
                               output int t_first);
        t_first = 0;
        for (int i = 0; i < w.size(); i++) begin
            @(posedge clk); #1;
            if (i == 0) t_first = cyc;
            in_valid   = 1'b1;
            in_data    = w[i];
            in_last    = with_last && (i == w.size() - 1);
            cfg_repeat = (i == 0) ? rep : REP_W'($urandom);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = word_t'($urandom);
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (exp_data.num() == 0 && busy === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic rand_words(input int n, output word_t w[$]);
        w = {};
        for (int i = 0; i < n; i++) w.push_back(word_t'($urandom));
    endtask

    task automatic test_reset;
        rstn = 1'b0; in_valid = 1'b1; in_last = 1'b0; in_data = word_t'($urandom); cfg_repeat = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({mem_we, mem_en, out_valid, out_last, out_data, busy, err_gap, err_ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got we=%b en=%b v=%b l=%b d=%h busy=%b eg=%b eo=%b expected all 0",
                     mem_we, mem_en, out_valid, out_last, out_data, busy, err_gap, err_ovf);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b expected 1", in_ready);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_frame(input string name, input word_t w[$], input logic [REP_W-1:0] rep);
        int t0; bit to;
        ovf_q = {}; gap_q = {};
        drive_frame(w, rep, 1'b1, t0);
        model_frame(w, rep, t0 + w.size() - 1);
        wait_idle(20 * (w.size() + 2) + 40, to);
        n_checks++;
        if (to || ovf_q.size() != 0 || gap_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s got timeout=%b ovf=%0d gap=%0d pending=%0d expected 0/0/0/0",
                     name, to, ovf_q.size(), gap_q.size(), exp_data.num());
        end
    endtask

    task automatic test_basic;
        word_t w[$];
        w = {word_t'(1), word_t'(2), word_t'(3), word_t'(4)};
        test_frame("basic", w, 4'd1);
        w = {word_t'('hA), word_t'('hB), word_t'('hC)};
        test_frame("repeat2", w, 4'd2);
        w = {word_t'('h5A5A5)};
        test_frame("single_rep0", w, 4'd0);
    endtask

    task automatic test_random;
        word_t w[$];
        for (int k = 0; k < 8; k++) begin
            rand_words($urandom_range(1, 24), w);
            test_frame("random", w, REP_W'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    // Second frame starts in the cycle right after the first one's last read.
    task automatic test_back_to_back;
        word_t a[$], b[$]; int ta, tb, lr; bit to;
        rand_words(3, a);
        rand_words(5, b);
        drive_frame(a, 4'd2, 1'b1, ta);
        model_frame(a, 4'd2, ta + 2);
        lr = (ta + 2) + 2 + (2 - 1) * (3 + 1) + 3 - 1;
        while (cyc < lr) begin @(posedge clk); #1; end
        drive_frame(b, 4'd1, 1'b1, tb);
        model_frame(b, 4'd1, tb + 4);
        wait_idle(200, to);
        n_checks++;
        if (to || tb != lr + 1) begin
            n_fail++;
            $display("FAIL back_to_back got timeout=%b start=%0d expected 0/%0d", to, tb, lr + 1);
        end
    endtask

    task automatic test_overflow;
        word_t w[$]; int t0; bit to;
        ovf_q = {}; gap_q = {};
        rand_words(130, w);
        drive_frame(w, 4'd1, 1'b1, t0);
        model_frame(w, 4'd1, t0 + 129);
        wait_idle(400, to);
        n_checks++;
        if (to || ovf_q.size() != 1 || gap_q.size() != 0) begin
            n_fail++;
            $display("FAIL overflow_pulse got timeout=%b ovf=%0d gap=%0d expected 0/1/0", to, ovf_q.size(), gap_q.size());
        end else begin
            n_checks++;
            if (ovf_q[0] != t0 + 128) begin
                n_fail++;
                $display("FAIL overflow_cycle got %0d expected %0d", ovf_q[0], t0 + 128);
            end
        end
    endtask

    task automatic test_gap;
        word_t w[$], p[$]; int t0; bit to;
        ovf_q = {}; gap_q = {};
        rand_words(5, w);
        p = {w[0], w[1]};
        drive_frame(p, 4'd3, 1'b0, t0);
        repeat (12) @(posedge clk);
        #2;
        n_checks++;
        if (gap_q.size() != 1 || busy !== 1'b0 || ovf_q.size() != 0) begin
            n_fail++;
            $display("FAIL gap_abort got gaps=%0d busy=%b ovf=%0d expected 1/0/0", gap_q.size(), busy, ovf_q.size());
        end else begin
            n_checks++;
            if (gap_q[0] != t0 + 3) begin
                n_fail++;
                $display("FAIL gap_cycle got %0d expected %0d", gap_q[0], t0 + 3);
            end
        end
        drive_frame(w, 4'd2, 1'b1, t0);
        model_frame(w, 4'd2, t0 + 4);
        wait_idle(100, to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL gap_recover got timeout=1 pending=%0d expected timeout=0", exp_data.num());
        end
    endtask

    task automatic test_reset_play;
        word_t w[$]; int t0, tl; int keys[$]; bit to;
        rand_words(6, w);
        drive_frame(w, 4'd1, 1'b1, t0);
        tl = t0 + 5;
        model_frame(w, 4'd1, tl);
        while (cyc < tl + 4) begin @(posedge clk); #1; end
        rstn = 1'b0;
        foreach (exp_data[c]) if (c > tl + 4) keys.push_back(c);
        foreach (keys[i]) begin exp_data.delete(keys[i]); exp_last.delete(keys[i]); end
        @(negedge clk);
        n_checks++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_strobes got en=%b we=%b expected 0/0", mem_en, mem_we);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_play got v=%b busy=%b ready=%b expected 0/0/1", out_valid, busy, in_ready);
        end
        wait_idle(20, to);
        rand_words(6, w);
        test_frame("after_reset", w, 4'd2);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL reset_drain got timeout=1 expected 0");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_overflow();
        test_gap();
        test_reset_play();
        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish expected finish before time limit");
        $fatal(1);
    end

endmodule
